// File: rtl/id_stage_pipe.sv
// Instruction-decode stage: register file, load-use stall, registered valid/ready output; 1-cycle latency.
// Optional macro ID_WB_BYPASS_EN makes the read ports return same-cycle writeback data.
module id_stage_pipe #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32,
   parameter int REG_AW   = 5,
   parameter int PC_W     = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PC_W-1:0]   in_pc,
   input  logic [31:0]       in_instr,
   input  logic              flush,
   input  logic [REG_AW-1:0] ex_dest,
   input  logic              ex_mem_read,
   input  logic              wb_en,
   input  logic [REG_AW-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   out_pc,
   output logic [3:0]        out_ex_cmd,
   output logic [DATA_W-1:0] out_reg1,
   output logic [DATA_W-1:0] out_reg2,
   output logic [DATA_W-1:0] out_op2,
   output logic [REG_AW-1:0] out_dest,
   output logic              out_wb_en,
   output logic              out_mem_read,
   output logic              out_mem_write,
   output logic              out_branch,
   output logic              hazard_stall
);

   logic [4:0]        opcode;
   logic [REG_AW-1:0] rs, rt, rd;
   logic [DATA_W-1:0] imm_ext;
   logic [5:0]        unused_instr_bits;

   assign opcode            = in_instr[4:0];
   assign rs                = in_instr[21 +: REG_AW];
   assign rt                = in_instr[16 +: REG_AW];
   assign rd                = in_instr[11 +: REG_AW];
   assign imm_ext           = DATA_W'($signed(in_instr[31:16]));
   assign unused_instr_bits = in_instr[10:5];

   logic [3:0] dec_cmd;
   logic       dec_imm, dec_wb, dec_mr, dec_mw, dec_br, dec_reads_rt;

   always_comb begin
      dec_cmd      = 4'd0;
      dec_imm      = 1'b0;
      dec_wb       = 1'b0;
      dec_mr       = 1'b0;
      dec_mw       = 1'b0;
      dec_br       = 1'b0;
      dec_reads_rt = 1'b0;
      case (opcode)
         5'd1, 5'd2, 5'd3, 5'd4, 5'd5: begin
            dec_cmd      = 4'(opcode);
            dec_wb       = 1'b1;
            dec_reads_rt = 1'b1;
         end
         5'd6: begin
            dec_cmd = 4'd1;
            dec_imm = 1'b1;
            dec_wb  = 1'b1;
         end
         5'd7: begin
            dec_cmd = 4'd1;
            dec_imm = 1'b1;
            dec_wb  = 1'b1;
            dec_mr  = 1'b1;
         end
         5'd8: begin
            dec_cmd      = 4'd1;
            dec_imm      = 1'b1;
            dec_mw       = 1'b1;
            dec_reads_rt = 1'b1;
         end
         5'd9: begin
            dec_cmd      = 4'd2;
            dec_br       = 1'b1;
            dec_reads_rt = 1'b1;
         end
         default: ;
      endcase
   end

   logic [DATA_W-1:0] rf_q [NUM_REGS];
   logic [DATA_W-1:0] rd1, rd2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
      end else if (wb_en && (wb_addr != '0)) begin
         rf_q[wb_addr] <= wb_data;
      end
   end

   always_comb begin
      rd1 = rf_q[rs];
      rd2 = rf_q[rt];
`ifdef ID_WB_BYPASS_EN
      if (wb_en && (wb_addr == rs)) rd1 = wb_data;
      if (wb_en && (wb_addr == rt)) rd2 = wb_data;
`endif
      // r0 is hardwired; this also masks any bypass aimed at it
      if (rs == '0) rd1 = '0;
      if (rt == '0) rd2 = '0;
   end

   logic out_valid_q, out_valid_d, xfer;

   assign hazard_stall = in_valid & ex_mem_read & (ex_dest != '0) &
                         ((ex_dest == rs) | ((ex_dest == rt) & dec_reads_rt));
   assign in_ready     = (~out_valid_q | out_ready) & ~hazard_stall;
   assign xfer         = in_valid & in_ready & ~flush;

   always_comb begin
      out_valid_d = out_valid_q;
      if (flush)          out_valid_d = 1'b0;
      else if (xfer)      out_valid_d = 1'b1;
      else if (out_ready) out_valid_d = 1'b0;
   end

   logic [PC_W-1:0]   pc_q;
   logic [3:0]        cmd_q;
   logic [DATA_W-1:0] reg1_q, reg2_q, op2_q;
   logic [REG_AW-1:0] dest_q;
   logic              wb_q, mr_q, mw_q, br_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         pc_q        <= '0;
         cmd_q       <= '0;
         reg1_q      <= '0;
         reg2_q      <= '0;
         op2_q       <= '0;
         dest_q      <= '0;
         wb_q        <= 1'b0;
         mr_q        <= 1'b0;
         mw_q        <= 1'b0;
         br_q        <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         if (xfer) begin
            pc_q   <= in_pc;
            cmd_q  <= dec_cmd;
            reg1_q <= rd1;
            reg2_q <= rd2;
            op2_q  <= dec_imm ? imm_ext : rd2;
            dest_q <= dec_imm ? rt : rd;
            wb_q   <= dec_wb;
            mr_q   <= dec_mr;
            mw_q   <= dec_mw;
            br_q   <= dec_br;
         end
      end
   end

   assign out_valid     = out_valid_q;
   assign out_pc        = pc_q;
   assign out_ex_cmd    = cmd_q;
   assign out_reg1      = reg1_q;
   assign out_reg2      = reg2_q;
   assign out_op2       = op2_q;
   assign out_dest      = dest_q;
   assign out_wb_en     = wb_q;
   assign out_mem_read  = mr_q;
   assign out_mem_write = mw_q;
   assign out_branch    = br_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: table-driven reference model checked every cycle plus hand-computed spot checks.
module tb_id_stage_pipe;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int PW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready;
   logic [PW-1:0] in_pc;
   logic [31:0]   in_instr;
   logic          flush;
   logic [AW-1:0] ex_dest;
   logic          ex_mem_read;
   logic          wb_en;
   logic [AW-1:0] wb_addr;
   logic [DW-1:0] wb_data;
   logic          out_valid, out_ready;
   logic [PW-1:0] out_pc;
   logic [3:0]    out_ex_cmd;
   logic [DW-1:0] out_reg1, out_reg2, out_op2;
   logic [AW-1:0] out_dest;
   logic          out_wb_en, out_mem_read, out_mem_write, out_branch;
   logic          hazard_stall;

   id_stage_pipe #(.DATA_W(DW), .NUM_REGS(32), .REG_AW(AW), .PC_W(PW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
      .in_instr(in_instr), .flush(flush), .ex_dest(ex_dest), .ex_mem_read(ex_mem_read),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_pc(out_pc), .out_ex_cmd(out_ex_cmd), .out_reg1(out_reg1),
      .out_reg2(out_reg2), .out_op2(out_op2), .out_dest(out_dest), .out_wb_en(out_wb_en),
      .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .out_branch(out_branch),
      .hazard_stall(hazard_stall)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Decode table by opcode; anything above 9 behaves like opcode 0
   int unsigned t_cmd[10]  = '{0, 1, 2, 3, 4, 5, 1, 1, 1, 2};
   bit          t_imm[10]  = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 0};
   bit          t_wb[10]   = '{0, 1, 1, 1, 1, 1, 1, 1, 0, 0};
   bit          t_mr[10]   = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
   bit          t_mw[10]   = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
   bit          t_br[10]   = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
   bit          t_rdrt[10] = '{0, 1, 1, 1, 1, 1, 0, 0, 1, 1};

   logic [DW-1:0] mrf [32];
   logic          mv;
   logic [PW-1:0] mpc;
   logic [3:0]    mcmd;
   logic [DW-1:0] mr1, mr2, mop2;
   logic [AW-1:0] mdest;
   logic          mwb, mmr, mmw, mbr;

   int            op;
   logic [4:0]    f_rs, f_rt, f_rd;
   logic [DW-1:0] v1, v2, vimm;
   logic          m_hz, m_rdy;

   always_comb begin
      op   = int'(in_instr[4:0]);
      if (op > 9) op = 0;
      f_rs = in_instr[25:21];
      f_rt = in_instr[20:16];
      f_rd = in_instr[15:11];
      vimm = {{16{in_instr[31]}}, in_instr[31:16]};
      v1   = (f_rs == 0) ? 32'h0 : mrf[f_rs];
      v2   = (f_rt == 0) ? 32'h0 : mrf[f_rt];
`ifdef ID_WB_BYPASS_EN
      if (wb_en && wb_addr == f_rs && f_rs != 0) v1 = wb_data;
      if (wb_en && wb_addr == f_rt && f_rt != 0) v2 = wb_data;
`endif
      m_hz  = in_valid && ex_mem_read && ex_dest != 0 &&
              (ex_dest == f_rs || (ex_dest == f_rt && t_rdrt[op]));
      m_rdy = (!mv || out_ready) && !m_hz;
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) mrf[i] <= '0;
         mv <= 0; mpc <= 0; mcmd <= 0; mr1 <= 0; mr2 <= 0; mop2 <= 0;
         mdest <= 0; mwb <= 0; mmr <= 0; mmw <= 0; mbr <= 0;
      end else begin
         if (wb_en && wb_addr != 0) mrf[wb_addr] <= wb_data;
         if (flush) mv <= 0;
         else if (in_valid && m_rdy) begin
            mv    <= 1;
            mpc   <= in_pc;
            mcmd  <= 4'(t_cmd[op]);
            mr1   <= v1;
            mr2   <= v2;
            mop2  <= t_imm[op] ? vimm : v2;
            mdest <= t_imm[op] ? f_rt : f_rd;
            mwb   <= t_wb[op];
            mmr   <= t_mr[op];
            mmw   <= t_mw[op];
            mbr   <= t_br[op];
         end else if (out_ready) mv <= 0;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("m_in_ready", in_ready, m_rdy);
         chk("m_hazard", hazard_stall, m_hz);
         chk("m_valid", out_valid, mv);
         if (mv) begin
            chk("m_pc", out_pc, mpc);
            chk("m_cmd", out_ex_cmd, mcmd);
            chk("m_reg1", out_reg1, mr1);
            chk("m_reg2", out_reg2, mr2);
            chk("m_op2", out_op2, mop2);
            chk("m_dest", out_dest, mdest);
            chk("m_ctrl", {out_wb_en, out_mem_read, out_mem_write, out_branch},
                {mwb, mmr, mmw, mbr});
         end
      end
   end

   function automatic logic [31:0] mk(input int o, input int s, input int t, input int d);
      return (32'(s) << 21) | (32'(t) << 16) | (32'(d) << 11) | 32'(o);
   endfunction

   function automatic logic [31:0] mki(input int o, input logic [15:0] imm);
      return {imm, 11'b0, 5'(o)};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wb_en = 1; wb_addr = a; wb_data = d;
      cyc();
      wb_en = 0;
   endtask

   task automatic issue(input logic [PW-1:0] pc, input logic [31:0] ins);
      in_valid = 1; in_pc = pc; in_instr = ins;
      cyc();
   endtask

   initial begin
      rst = 1; in_valid = 0; in_pc = 0; in_instr = 0; flush = 0; ex_dest = 0;
      ex_mem_read = 0; wb_en = 0; wb_addr = 0; wb_data = 0; out_ready = 1;
      cyc(); cyc();
      rst = 0;
      cyc();
      chk("reset_valid", out_valid, 0);
      chk("reset_pc", out_pc, 0);

      wr(3, 32'h10); wr(5, 32'h77); wr(9, 32'h55); wr(1, 32'h21);

      issue(32'h100, mk(1, 3, 3, 4));
      chk("add_valid", out_valid, 1);
      chk("add_cmd", out_ex_cmd, 1);
      chk("add_reg1", out_reg1, 32'h10);
      chk("add_op2", out_op2, 32'h10);
      chk("add_dest", out_dest, 4);
      chk("add_pc", out_pc, 32'h100);

      issue(32'h104, mki(6, 16'hFFE2));
      chk("addi_op2", out_op2, 32'hFFFF_FFE2);
      chk("addi_dest", out_dest, 2);
      chk("addi_wb", out_wb_en, 1);

      ex_mem_read = 1; ex_dest = 7; in_pc = 32'h108; in_instr = mk(1, 7, 1, 8);
      #1;
      chk("haz_rs_stall", hazard_stall, 1);
      chk("haz_rs_ready", in_ready, 0);
      cyc();
      chk("haz_bubble", out_valid, 0);
      ex_mem_read = 0;
      cyc();
      chk("haz_accept", out_valid, 1);
      chk("haz_accept_pc", out_pc, 32'h108);

      ex_mem_read = 1; ex_dest = 5;
      in_pc = 32'h10C; in_instr = mki(8, 16'h0025);
      #1;
      chk("haz_sw_rt", hazard_stall, 1);
      cyc();
      in_instr = mki(6, 16'h0025);
      #1;
      chk("no_haz_addi_rt", hazard_stall, 0);
      cyc();
      ex_dest = 0; in_instr = mk(1, 0, 0, 3);
      #1;
      chk("no_haz_r0", hazard_stall, 0);
      cyc();
      ex_mem_read = 0;

      issue(32'h110, mki(7, 16'h0066));
      issue(32'h114, mki(8, 16'h8025));
      issue(32'h118, mk(9, 1, 5, 0));
      issue(32'h11C, mk(5, 5, 1, 10));
      issue(32'h120, mk(2, 5, 3, 11));
      issue(32'h124, mk(3, 5, 1, 12));
      issue(32'h128, mk(4, 5, 1, 13));
      issue(32'h12C, mk(15, 3, 3, 3));
      chk("nop_cmd", out_ex_cmd, 0);
      chk("nop_ctrl", {out_wb_en, out_mem_read, out_mem_write, out_branch}, 0);

      issue(32'h130, mk(2, 3, 5, 14));
      out_ready = 0; in_pc = 32'h134; in_instr = mk(1, 1, 1, 15);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("hold_pc", out_pc, 32'h130);
         chk("hold_ready", in_ready, 0);
      end
      flush = 1;
      cyc();
      chk("flush_valid", out_valid, 0);
      flush = 0; in_valid = 0; out_ready = 1;
      cyc();
      chk("flush_dropped", out_valid, 0);

      wb_en = 1; wb_addr = 9; wb_data = 32'hAB;
      issue(32'h140, mk(1, 9, 0, 12));
      wb_en = 0;
`ifdef ID_WB_BYPASS_EN
      chk("same_cycle_wb", out_reg1, 32'hAB);
`else
      chk("same_cycle_wb", out_reg1, 32'h55);
`endif
      issue(32'h144, mk(1, 9, 0, 12));
      chk("after_wb", out_reg1, 32'hAB);

      in_valid = 0;
      wr(0, 32'hDEAD);
      issue(32'h148, mk(1, 0, 0, 13));
      chk("r0_reg1", out_reg1, 0);

      ex_mem_read = 1; ex_dest = 3; flush = 1;
      issue(32'h14C, mk(1, 3, 0, 1));
      chk("flush_over_haz", out_valid, 0);
      flush = 0; ex_mem_read = 0;

      issue(32'h150, mk(1, 3, 3, 6));
      chk("pre_rst_valid", out_valid, 1);
      #3 rst = 1;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_pc", out_pc, 0);
      chk("arst_reg1", out_reg1, 0);
      chk("arst_cmd", out_ex_cmd, 0);
      chk("arst_wb", out_wb_en, 0);
      cyc();
      rst = 0; in_valid = 0;
      cyc();
      chk("rst_drop", out_valid, 0);
      issue(32'h160, mk(1, 5, 0, 14));
      chk("rst_r5", out_reg1, 0);
      in_valid = 0;
      cyc(); cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
